// File: rtl/ram_bank_clr.sv
// ram_bank_clr: true dual-port RAM with lane write enables, RDW mode, optional output register and clear engine
module ram_bank_clr #(
    parameter int              DATA     = 16,
    parameter int              ADDR     = 13,
    parameter int              LANES    = 2,
    parameter int              RDW_MODE = 0,
    parameter int              OUT_REG  = 0,
    parameter logic [DATA-1:0] CLR_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    output logic             clr_busy,
    input  logic             a_en,
    input  logic [LANES-1:0] a_we,
    input  logic [ADDR-1:0]  a_addr,
    input  logic [DATA-1:0]  a_din,
    output logic [DATA-1:0]  a_dout,
    output logic             a_vld,
    input  logic             b_en,
    input  logic [LANES-1:0] b_we,
    input  logic [ADDR-1:0]  b_addr,
    input  logic [DATA-1:0]  b_din,
    output logic [DATA-1:0]  b_dout,
    output logic             b_vld
);
    localparam int LW = DATA / LANES;
    localparam logic [ADDR:0] LAST = (ADDR+1)'((1 << ADDR) - 1);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state_q, state_d;
    logic [DATA-1:0] mem [0:(1 << ADDR)-1];
    logic [ADDR:0] cnt_q, cnt_d;
    logic a_act, b_act;
    logic [LANES-1:0] a_wr, b_wr;
    logic [DATA-1:0] a_old, b_old, a_rd, b_rd;
    logic [DATA-1:0] a_s1_q, a_s1_d, b_s1_q, b_s1_d, a_s2_q, b_s2_q;
    logic a_v1_q, a_v1_d, b_v1_q, b_v1_d, a_v2_q, b_v2_q;
    always_comb begin
        a_act = a_en && state_q == IDLE && !rst;
        b_act = b_en && state_q == IDLE && !rst;
        a_wr = a_we & {LANES{a_act}};
        b_wr = b_we & {LANES{b_act}};
        a_old = mem[a_addr];
        b_old = mem[b_addr];
        a_rd = a_old;
        b_rd = b_old;
        for (int l = 0; l < LANES; l++) begin
            if (RDW_MODE == 0 && a_wr[l]) a_rd[l*LW +: LW] = a_din[l*LW +: LW];
            if (RDW_MODE == 0 && b_wr[l]) b_rd[l*LW +: LW] = b_din[l*LW +: LW];
        end
        a_s1_d = a_act ? a_rd : a_s1_q;
        b_s1_d = b_act ? b_rd : b_s1_q;
        a_v1_d = a_act;
        b_v1_d = b_act;
        state_d = state_q == CLEAR ? (cnt_q == LAST ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
        cnt_d = state_q == CLEAR ? cnt_q + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q <= '0;
            a_s1_q <= '0;
            b_s1_q <= '0;
            a_s2_q <= '0;
            b_s2_q <= '0;
            a_v1_q <= 1'b0;
            b_v1_q <= 1'b0;
            a_v2_q <= 1'b0;
            b_v2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            a_s1_q <= a_s1_d;
            b_s1_q <= b_s1_d;
            a_s2_q <= a_s1_q;
            b_s2_q <= b_s1_q;
            a_v1_q <= a_v1_d;
            b_v1_q <= b_v1_d;
            a_v2_q <= a_v1_q;
            b_v2_q <= b_v1_q;
        end
    end
    // Port A is written last so it wins lanes that both ports enable on one address
    always_ff @(posedge clk) begin
        if (!rst && state_q == CLEAR) mem[cnt_q[ADDR-1:0]] <= CLR_VAL;
        for (int l = 0; l < LANES; l++) begin
            if (b_wr[l]) mem[b_addr][l*LW +: LW] <= b_din[l*LW +: LW];
            if (a_wr[l]) mem[a_addr][l*LW +: LW] <= a_din[l*LW +: LW];
        end
    end
    assign clr_busy = state_q == CLEAR;
    assign a_dout = OUT_REG != 0 ? a_s2_q : a_s1_q;
    assign b_dout = OUT_REG != 0 ? b_s2_q : b_s1_q;
    assign a_vld = OUT_REG != 0 ? a_v2_q : a_v1_q;
    assign b_vld = OUT_REG != 0 ? b_v2_q : b_v1_q;
endmodule

// File: doc/ram_bank_clr.md
Name: ram_bank_clr

Overview:
- Parametrised, single-clock, true dual-port block RAM for the candidate/hash buffers.
- Adds over the plain dual-port RAM: per-lane byte-style write enables, selectable read-during-write mode, an optional output register stage, deterministic same-address collision rules, and a hardware clear engine.
- The clear engine sweeps the whole memory after reset or on request.
- Sits between the work dispatcher and the hash cores; the dispatcher waits on clr_busy before loading.

Parameters:
- DATA, 16: word width in bits; must be divisible by LANES.
- ADDR, 13: address width; depth is 2**ADDR.
- LANES, 2: write-enable lanes; lane width is DATA/LANES.
- RDW_MODE, 0: same-port read-during-write. 0 = write-first (dout shows new data), 1 = read-first (dout shows old data).
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, latency 2.
- CLR_VAL, 0: DATA-wide value written to every word by the clear engine.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  single-cycle pulse that starts a memory clear.
- clr_busy  out  1  high while a clear is in progress or rst is asserted.
- a_en  in  1  port A access enable.
- a_we  in  LANES  port A per-lane write enable; only meaningful when a_en=1.
- a_addr  in  ADDR  port A address.
- a_din  in  DATA  port A write data.
- a_dout  out  DATA  port A read data.
- a_vld  out  1  port A read data valid.
- b_en, b_we, b_addr, b_din, b_dout, b_vld: same widths and meaning for port B.

Behaviour:
- Reset (rst=1 at a posedge):
  - a_dout, b_dout, all pipeline registers = 0; a_vld = b_vld = 0; clr_busy = 1.
  - Clear counter = 0; FSM forced to CLEAR.
  - Memory contents are not touched while rst is held.
- FSM states are CLEAR and IDLE.
  - CLEAR: on each clk with rst=0, write CLR_VAL to mem[cnt] and increment cnt.
  - When cnt = 2**ADDR-1 is written, go to IDLE and drop clr_busy on the next cycle.
  - clr_busy is high for exactly 2**ADDR cycles after rst deasserts.
  - IDLE: clr_req=1 at a posedge moves to CLEAR with cnt=0; clr_busy=1 from the next cycle.
  - clr_req is ignored while in CLEAR.
  - rst mid-clear restarts the sweep from address 0.
- While clr_busy=1:
  - All port accesses are ignored; no memory write from either port.
  - a_vld and b_vld stay 0; dout holds its value.
  - Requests in the cycle where clr_busy falls are ignored.
- Port access (IDLE):
  - Lane i of mem[addr] is written with din lane i when en=1 and we[i]=1.
  - A read occurs whenever en=1, including cycles with writes.
  - vld pulses high exactly 1 cycle after en (OUT_REG=0) or 2 cycles after (OUT_REG=1).
  - dout holds its last value when not updated.
- Same-port read-during-write (RDW_MODE):
  - Mode 0: dout equals din on written lanes and old memory data on unwritten lanes.
  - Mode 1: dout equals the old word.
- Cross-port, same address, same cycle:
  - Both write: port A wins on lanes both enable; lanes enabled by only one port take that port's data.
  - One writes, the other reads: the reader gets the old word, regardless of RDW_MODE.
- Different addresses: ports are fully independent.
- Address wrap: the clear counter is ADDR+1 bits internally so termination is exact; ports have no wrap behaviour (addresses are full-range).
- OUT_REG=1: the second stage captures stage-1 data and valid every cycle; reset clears both stages.

Test Plan:
- Reset/clear (DATA=16, ADDR=4, CLR_VAL=16'hA5A5): pulse rst, release -> clr_busy high 16 cycles then low; reads of addr 0..15 all return A5A5 with vld 1 cycle later.
- Lane writes: write A addr 3 din=1234 we=11, then write A addr 3 din=ABCD we=01 -> read returns 12CD.
- RDW modes: mem[5]=1111; A writes 2222 to addr 5 with a read in the same cycle -> a_dout=2222 in mode 0, 1111 in mode 1.
- Collision: A writes 0x00FF we=01 and B writes 0xEE00 we=11 to addr 7 in the same cycle -> mem[7]=EEFF. Repeat with A we=11 din=AAAA -> AAAA.
- Busy lockout: in IDLE write mem[2]=7777, pulse clr_req, attempt a write of 5555 to addr 2 during busy -> ignored, no vld; after busy, mem[2]=CLR_VAL.
- Latency and reset mid-clear (OUT_REG=1): a read shows vld exactly 2 cycles after en. Assert rst at cycle 8 of a clear -> clr_busy stays high a full 16 cycles after release.
